// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: NUM_SRC byte-wide AXI-Stream sources share one
// downstream sink, with whole frames granted and a programmable idle gap between frames.
//
// state | meaning
// IDLE  | no grant; arbitrate among requesting sources when enabled
// XFER  | granted source's lanes routed to m_axis until its tlast beat
// GAP   | inter-frame gap, m_axis idle, all sources held off
module axis_frame_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           frames_granted
);

    localparam int GW = $clog2(NUM_SRC);
    localparam logic [7:0] GAP_LOAD = 8'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   sel_idx;
    logic            sel_valid;
    logic [GW:0]     cand;
    logic [7:0]      gap_cnt, gap_cnt_nxt;
    logic [7:0]      lane_data [NUM_SRC];
    logic            beat_last;
    logic            grant_now;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        assign lane_data[i] = s_axis_tdata[8*i +: 8];
    end

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_SRC)) begin
                cand = cand - (GW+1)'(NUM_SRC);
            end
            if (s_axis_tvalid[cand[GW-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == XFER) begin
            m_axis_tdata            = lane_data[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tlast            = s_axis_tlast[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
        end
    end

    assign beat_last = (state == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign grant_now = (state == IDLE) && enable && sel_valid;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (grant_now) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (beat_last) begin
                    if (IFG_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            grant_id       <= '0;
            last_grant     <= GW'(NUM_SRC - 1);
            frames_granted <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (grant_now) begin
                grant_id   <= sel_idx;
                last_grant <= sel_idx;
            end
            if (beat_last) begin
                frames_granted <= frames_granted + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: scenario table with per-source byte scoreboards,
// plus hand sequences for enable gating, reset mid-frame and a zero-gap build.
module tb_axis_frame_arbiter;

    localparam int NS  = 4;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tready, s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [1:0]  grant_id;
    logic        busy;
    logic [31:0] frames_granted;

    logic [15:0] z_tdata;
    logic [1:0]  z_tvalid, z_tready, z_tlast;
    logic [7:0]  zm_tdata;
    logic        zm_tvalid, zm_tready, zm_tlast;
    logic [0:0]  z_grant;
    logic        z_busy;
    logic [7:0]  z_frames;

    always #5 clk = ~clk;

    axis_frame_arbiter #(.NUM_SRC(NS), .IFG_CYCLES(IFG), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy), .frames_granted(frames_granted)
    );

    axis_frame_arbiter #(.NUM_SRC(2), .IFG_CYCLES(0), .CNT_W(8)) dut_z (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tready(z_tready),
        .s_axis_tlast(z_tlast),
        .m_axis_tdata(zm_tdata), .m_axis_tvalid(zm_tvalid), .m_axis_tready(zm_tready),
        .m_axis_tlast(zm_tlast),
        .grant_id(z_grant), .busy(z_busy), .frames_granted(z_frames)
    );

    typedef struct {
        bit          rst_first;
        logic [15:0] nfr;      // frames per source, one nibble each
        int          len;
        bit          bubble;   // source 1 drops tvalid randomly
        bit          bp;       // random m_axis_tready
        bit          exact;    // sources always ready, so gap must be exactly IFG+2
        int          n_exp;
        logic [31:0] order;    // expected grant order, nibble 0 first
    } scen_t;

    scen_t scen [5];

    int n_vec = 0, n_err = 0;
    int src_q [NS][$];
    int exp_q [NS][$];
    int exp_grant_q [$];
    bit bubble_en, bp_en, exact_gap, in_frame, have_last;
    int cyc = 0, last_tlast_cyc, cur_grant, beat_idx, frames_exp, frame_seed = 5;
    int n;
    int z_rem [2];
    int zc, z_tlast0, z_first1, z_first_grant;
    logic [1:0] z_hs;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        int v;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0 && !(bubble_en && i == 1 && $urandom_range(0, 3) == 0)) begin
                v                = src_q[i][0];
                s_tvalid[i]      = 1'b1;
                s_tdata[8*i +: 8] = v[7:0];
                s_tlast[i]       = v[8];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
            end
        end
        m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic load_frame(input int src, input int len);
        int v;
        for (int k = 0; k < len; k++) begin
            v = ((src * 53 + k * 7 + frame_seed) & 255) | ((k == len - 1) ? 256 : 0);
            src_q[src].push_back(v);
            exp_q[src].push_back(v);
        end
        frame_seed += 11;
        frames_exp++;
    endtask

    task automatic cycle();
        logic [3:0] hs;
        int v;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        chk("tready_isolation", s_tready & ~(4'b0001 << grant_id), 0);
        if (m_tvalid && m_tready) begin
            chk("busy_during_beat", busy, 1);
            if (!in_frame) begin
                if (exp_grant_q.size() == 0) chk("unexpected_grant", grant_id, 99);
                else chk("grant_order", grant_id, exp_grant_q.pop_front());
                if (have_last) begin
                    chk("ifg_min", (cyc - last_tlast_cyc) >= IFG + 2, 1);
                    if (exact_gap) chk("ifg_exact", cyc - last_tlast_cyc, IFG + 2);
                end
                in_frame  = 1;
                cur_grant = grant_id;
                beat_idx  = 0;
            end else begin
                chk("no_interleave", grant_id, cur_grant);
            end
            if (exp_q[grant_id].size() == 0) begin
                chk("beat_without_frame", m_tdata, 999);
            end else begin
                v = exp_q[grant_id].pop_front();
                chk("beat_data_last", {m_tlast, m_tdata}, v);
            end
            beat_idx++;
            if (m_tlast) begin
                in_frame       = 0;
                have_last      = 1;
                last_tlast_cyc = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NS; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_inputs();
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) p = 1;
        return p || in_frame || exp_grant_q.size() > 0;
    endfunction

    task automatic run_until_done(input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            cycle();
            k++;
        end
        chk("scenario_timeout", k < budget, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_granted, 0);
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        exp_grant_q.delete();
        in_frame   = 0;
        have_last  = 0;
        frames_exp = 0;
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        scen[0] = '{0, 16'h0100, 64, 0, 0, 0, 1, 32'h2};
        scen[1] = '{1, 16'h1112, 64, 0, 0, 1, 5, 32'h03210};
        scen[2] = '{0, 16'h0020, 40, 1, 1, 0, 2, 32'h11};
        scen[3] = '{0, 16'h1101, 20, 0, 0, 1, 3, 32'h032};
        scen[4] = '{0, 16'h1111, 1,  0, 0, 1, 4, 32'h0321};

        enable    = 1'b1;
        bubble_en = 0;
        bp_en     = 0;
        z_tdata   = '0;
        z_tvalid  = '0;
        z_tlast   = '0;
        zm_tready = 1'b1;
        s_tdata   = '0;
        s_tvalid  = '0;
        s_tlast   = '0;
        m_tready  = 1'b1;
        apply_reset();

        for (int t = 0; t < 5; t++) begin
            if (scen[t].rst_first) apply_reset();
            bubble_en = scen[t].bubble;
            bp_en     = scen[t].bp;
            exact_gap = scen[t].exact;
            have_last = 0;
            for (int i = 0; i < NS; i++)
                for (int f = 0; f < int'(scen[t].nfr[4*i +: 4]); f++) load_frame(i, scen[t].len);
            for (int g = 0; g < scen[t].n_exp; g++) exp_grant_q.push_back(int'(scen[t].order[4*g +: 4]));
            drive_inputs();
            run_until_done(4000);
            bubble_en = 0;
            bp_en     = 0;
            drive_inputs();
            repeat (IFG + 4) cycle();
            chk("frames_granted", frames_granted, frames_exp);
        end

        // enable dropped while source 3 is mid-frame, sources 0 and 1 waiting
        exact_gap = 0;
        load_frame(3, 30);
        exp_grant_q.push_back(3);
        drive_inputs();
        n = 0;
        while (!in_frame && n < 20) begin cycle(); n++; end
        chk("en_src3_started", in_frame, 1);
        enable = 1'b0;
        load_frame(0, 10);
        load_frame(1, 10);
        drive_inputs();
        n = 0;
        while ((src_q[3].size() > 0 || in_frame) && n < 200) begin cycle(); n++; end
        chk("en_src3_done", n < 200, 1);
        repeat (IFG + 10) cycle();
        chk("en_low_busy", busy, 0);
        chk("en_low_grant", grant_id, 3);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        enable = 1'b1;
        cycle();
        chk("en_high_grant", grant_id, 0);
        chk("en_high_busy", busy, 1);
        run_until_done(400);
        chk("en_frames", frames_granted, frames_exp);

        // reset asserted while beat 20 of a 100-byte frame is on the bus
        apply_reset();
        load_frame(2, 100);
        exp_grant_q.push_back(2);
        drive_inputs();
        n = 0;
        while (!(in_frame && beat_idx == 19) && n < 300) begin cycle(); n++; end
        chk("rst_reach_beat20", n < 300, 1);
        chk("rst_beat20_present", m_tvalid, 1);
        apply_reset();
        load_frame(0, 8);
        load_frame(3, 8);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(3);
        drive_inputs();
        run_until_done(400);
        chk("rst_recover_frames", frames_granted, 2);

        // zero-gap build: frames from sources 0 and 1 back to back
        z_rem[0] = 3;
        z_rem[1] = 3;
        zc = 0;
        z_tlast0 = -100;
        z_first1 = -1;
        z_first_grant = -1;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 2; i++) begin
                z_tvalid[i]       = z_rem[i] > 0;
                z_tdata[8*i +: 8] = 8'(i * 16 + 3 - z_rem[i]);
                z_tlast[i]        = z_rem[i] == 1;
            end
            @(negedge clk);
            z_hs = z_tvalid & z_tready;
            if (zm_tvalid && zm_tready) begin
                if (z_first_grant < 0) z_first_grant = int'(z_grant);
                if (zm_tlast && z_grant == 1'b0) z_tlast0 = zc;
                if (z_grant == 1'b1 && z_first1 < 0) begin
                    z_first1 = zc;
                    chk("ifg0_first_data", zm_tdata, 16);
                end
            end
            @(posedge clk);
            zc++;
            #1;
            for (int i = 0; i < 2; i++) if (z_hs[i] && z_rem[i] > 0) z_rem[i]--;
        end
        chk("ifg0_first_grant", z_first_grant, 0);
        chk("ifg0_spacing", z_first1 - z_tlast0, 2);
        chk("ifg0_frames", z_frames, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that lets NUM_SRC byte-wide AXI-Stream packet sources share one downstream fcs_tx instance.
- Once a source is granted, it keeps the grant until its tlast beat; frames are never interleaved.
- After every frame it enforces a programmable inter-frame gap, then re-arbitrates.
- Sits between the packet generators/MAC clients and fcs_tx; m_axis connects directly to fcs_tx s_axis.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- IFG_CYCLES, 12, idle cycles inserted after each frame's tlast beat (0..255).
- CNT_W, 32, width of the granted-frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants are issued; a frame in progress completes.
- s_axis_tdata  in  8*NUM_SRC  source i occupies bits [8*i+7:8*i].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- s_axis_tlast  in  NUM_SRC  per-source last.
- m_axis_tdata  out  8  to fcs_tx.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tlast  out  1.
- grant_id  out  $clog2(NUM_SRC)  index of the current/last granted source.
- busy  out  1  high in XFER and GAP.
- frames_granted  out  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset (async assert; deassert takes effect on the next clk edge):
  - state=IDLE; all s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0.
  - grant_id=0; last_grant=NUM_SRC-1, so source 0 has first priority; busy=0; frames_granted=0; gap counter=0.
- States: IDLE, XFER, GAP.
- IDLE:
  - If enable=1 and any s_axis_tvalid[i]=1, select the first requesting index searching last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register the selection into grant_id and last_grant; go to XFER next cycle.
  - Otherwise stay in IDLE. The decision uses registered state only; there is no combinational path from s_axis_tvalid to s_axis_tready.
- XFER:
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast are combinational copies of the granted source's lanes.
  - s_axis_tready[grant_id]=m_axis_tready; every other s_axis_tready is 0.
  - A beat transfers when m_axis_tvalid && m_axis_tready.
  - The source may drop tvalid mid-frame (bubble); the grant is held and the other sources stay blocked.
  - On a beat with tlast=1: frames_granted increments (wrapping) and the next state is GAP, or IDLE if IFG_CYCLES=0.
  - enable going low during XFER has no effect until the frame ends.
- GAP:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - The counter loads IFG_CYCLES-1 on entry and decrements each cycle; at 0 the next state is IDLE.
- Latency and spacing:
  - From the tlast transfer in cycle t, the earliest next first beat is in cycle t+IFG_CYCLES+2.
  - m_axis_tvalid is therefore low for at least IFG_CYCLES+1 cycles between frames.
  - Grant to first possible beat is 1 cycle.
- Fairness: a source that requests continuously waits at most NUM_SRC-1 frames.
- Single requester: it is re-granted after each gap.
- Simultaneous events: new requests arriving during XFER/GAP are ignored until IDLE. tvalid from a non-granted source is never forwarded.
- busy=1 in XFER and GAP, 0 in IDLE.
- Reset mid-frame: outputs return to their reset values immediately. The partially sent frame is truncated with no tlast; recovering from that is the sink's responsibility.
- No internal buffering; no data reordering.

Test Plan:
- Single source: NUM_SRC=4, IFG_CYCLES=12, source 2 sends one 64-byte frame with m_axis_tready=1 -> 64 beats on m_axis, tlast only on beat 64, grant_id=2, frames_granted=1, m_axis_tvalid low for 13 cycles after tlast.
- All four sources request simultaneously after reset, each with 64-byte frames -> grants in order 0,1,2,3,0; no interleaving; every inter-frame gap is ≥13 cycles; frames_granted=5 after the fifth tlast.
- Backpressure: m_axis_tready toggled with a random 50% duty, and source 1 inserts tvalid bubbles mid-frame -> byte order is preserved, s_axis_tready[0,2,3] stays 0 throughout, and the tlast beat count matches.
- enable=0 while source 3 is mid-frame with sources 0 and 1 requesting -> source 3 completes its frame, then no grant is issued while enable=0; enable=1 -> source 0 is granted within 1 cycle.
- IFG_CYCLES=0 build, two back-to-back frames from sources 0 and 1 -> the second frame's first beat is in cycle t+2 after the tlast cycle t.
- Assert rst during beat 20 of a 100-byte frame -> m_axis_tvalid=0 and all s_axis_tready=0 immediately, frames_granted=0; after release the first grant goes to source 0 when it is requesting.
- End-to-end: 2000 frames of 64..256 bytes through fcs_tx and fcs_rx -> bad_fcs count is 0 and the per-source frame tally sums to 2000.
